// File: rtl/joy_db9md_scan_if.sv
// Host-side handshake of the DB9 Megadrive scan sequencer: scan request,
// progress flags and the published button words.
interface joy_db9md_scan_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [11:0] joystick1;
    logic [11:0] joystick2;
    logic        pad1_6btn;
    logic        pad2_6btn;

    modport master (
        output start,
        input  busy, done, joystick1, joystick2, pad1_6btn, pad2_6btn
    );

    modport slave (
        input  start,
        output busy, done, joystick1, joystick2, pad1_6btn, pad2_6btn
    );
endinterface

// File: rtl/joy_db9md_scan.sv
// On-demand scan sequencer for the Megadrive DB9 splitter: walks both pads
// through eight select phases, classifies them and publishes button words.
module joy_db9md_scan #(
    parameter int SETTLE  = 16,
    parameter int MIN_GAP = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       joy_in,
    output logic             joy_mdsel,
    output logic             joy_split,
    joy_db9md_scan_if.slave  host
);

    localparam int SW = $clog2(SETTLE);
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_SCAN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            launch;
    logic            slot_end;
    logic            scan_end;

    logic            pending;
    logic [SW-1:0]   settle_cnt;
    logic            slot;
    logic [2:0]      phase;
    logic [GW-1:0]   gap_cnt;
    logic            done_r;

    logic [1:0][11:0] shadow;
    logic [1:0]       md;
    logic [1:0]       six;
    logic [1:0][11:0] joy_word;
    logic [1:0]       pad_six;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        slot_end  = (state == ST_SCAN) && (settle_cnt == SW'(SETTLE - 1));
        scan_end  = slot_end && slot && (phase == 3'd7);
        unique case (state)
            ST_IDLE: begin
                if (host.start || pending) begin
                    state_nxt = ST_SCAN;
                    launch    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (scan_end) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Slot/phase sequencing, request latching and the post-scan quiet window
    // that lets 6-button pads drop their select count.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= 1'b0;
            settle_cnt <= '0;
            slot       <= 1'b0;
            phase      <= 3'd0;
            gap_cnt    <= '0;
            done_r     <= 1'b0;
        end else begin
            pending <= !launch && (pending || host.start);
            done_r  <= scan_end;

            if (launch) begin
                settle_cnt <= '0;
                slot       <= 1'b0;
                phase      <= 3'd0;
            end else if (state == ST_SCAN) begin
                if (slot_end) begin
                    settle_cnt <= '0;
                    slot       <= ~slot;
                    if (slot) begin
                        phase <= phase + 3'd1;
                    end
                end else begin
                    settle_cnt <= settle_cnt + SW'(1);
                end
            end

            if (scan_end) begin
                gap_cnt <= GW'(MIN_GAP - 1);
            end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

    // Pad identification: phase 1 grounds L/R on MD pads, phase 3 grounds
    // U/D/L/R on 6-button pads, phase 4 then presents Z/Y/X/Mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow   <= '0;
            md       <= '0;
            six      <= '0;
            joy_word <= '0;
            pad_six  <= '0;
        end else begin
            if (slot_end) begin
                case (phase)
                    3'd0: shadow[slot][5:0] <= ~joy_in;
                    3'd1: begin
                        if (joy_in[1:0] == 2'b00) begin
                            shadow[slot][7:6] <= ~joy_in[5:4];
                            md[slot]          <= 1'b1;
                        end else begin
                            shadow[slot][7:6] <= 2'b00;
                            md[slot]          <= 1'b0;
                        end
                    end
                    3'd3: six[slot] <= md[slot] && (joy_in[3:0] == 4'b0000);
                    3'd4: shadow[slot][11:8] <= six[slot] ? ~joy_in[3:0] : 4'b0000;
                    default: ;
                endcase
            end

            if (scan_end) begin
                joy_word <= shadow;
                pad_six  <= six;
            end
        end
    end

    assign joy_mdsel      = (state == ST_SCAN) ? ~phase[0] : 1'b1;
    assign joy_split      = (state == ST_SCAN) && slot;
    assign host.busy      = (state == ST_SCAN);
    assign host.done      = done_r;
    assign host.joystick1 = joy_word[0];
    assign host.joystick2 = joy_word[1];
    assign host.pad1_6btn = pad_six[0];
    assign host.pad2_6btn = pad_six[1];

endmodule

// File: tb/tb_joy_db9md_scan.sv
// Self-checking bench for joy_db9md_scan: behavioural SMS / 3-button /
// 6-button pad models behind the splitter, randomized buttons and pad types.
module tb_joy_db9md_scan;

    localparam int SETTLE   = 4;
    localparam int MIN_GAP  = 32;
    localparam int SCAN_LEN = 16 * SETTLE;
    localparam int PAD_SMS  = 0;
    localparam int PAD_3BTN = 1;
    localparam int PAD_6BTN = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] joy_in;
    logic       joy_mdsel;
    logic       joy_split;

    joy_db9md_scan_if host();

    joy_db9md_scan #(.SETTLE(SETTLE), .MIN_GAP(MIN_GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .joy_in    (joy_in),
        .joy_mdsel (joy_mdsel),
        .joy_split (joy_split),
        .host      (host)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    int          pad_type [2];
    logic [11:0] pad_btn  [2];
    int          falls    = 0;
    int          high_run = 0;
    logic        prev_sel = 1'b1;

    // Pads count select falling edges and forget them after a long high period.
    always @(posedge clk) begin
        high_run <= joy_mdsel ? high_run + 1 : 0;
        if (prev_sel && !joy_mdsel) begin
            falls <= falls + 1;
        end else if (joy_mdsel && high_run >= 3 * SETTLE) begin
            falls <= 0;
        end
        prev_sel <= joy_mdsel;
    end

    function automatic logic [5:0] padRaw(input int typ, input logic [11:0] b,
                                          input logic sel, input int f);
        if (typ == PAD_SMS) return ~b[5:0];
        if (sel) begin
            if (typ == PAD_6BTN && f == 2) return ~{b[5:4], b[11:8]};
            return ~b[5:0];
        end
        if (typ == PAD_6BTN && f == 2) return {~b[7:6], 4'b0000};
        return {~b[7:6], ~b[3:2], 2'b00};
    endfunction

    always_comb begin
        joy_in = joy_split ? padRaw(pad_type[1], pad_btn[1], joy_mdsel, falls)
                           : padRaw(pad_type[0], pad_btn[0], joy_mdsel, falls);
    end

    function automatic logic [11:0] expectWord(input int typ, input logic [11:0] b);
        case (typ)
            PAD_SMS:  return {6'b000000, b[5:0]};
            PAD_3BTN: return {4'b0000, b[7:0]};
            default:  return b;
        endcase
    endfunction

    // Opposite directions on one d-pad cannot be pressed together.
    function automatic logic [11:0] randBtn();
        logic [11:0] b;
        b = 12'($urandom);
        if (b[3] && b[2]) b[2] = 1'b0;
        if (b[1] && b[0]) b[0] = 1'b0;
        return b;
    endfunction

    task automatic setPadsRandom();
        for (int k = 0; k < 2; k++) begin
            pad_type[k] = int'($urandom_range(0, 2));
            pad_btn[k]  = randBtn();
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input int t1, input logic [11:0] b1,
                                 input int t2, input logic [11:0] b2);
        pad_type[0] = t1;
        pad_btn[0]  = b1;
        pad_type[1] = t2;
        pad_btn[1]  = b2;
        @(posedge clk);
        #1 host.start = 1'b1;
        @(posedge clk);
        #1 host.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkIdle(input string tag, input logic [11:0] j1,
                             input logic [11:0] j2, input logic [1:0] six);
        checkOutput({tag, " lines"}, {host.busy, host.done, joy_mdsel, joy_split}, 4'b0010);
        checkOutput({tag, " joystick1"}, host.joystick1, j1);
        checkOutput({tag, " joystick2"}, host.joystick2, j2);
        checkOutput({tag, " 6btn"}, {host.pad2_6btn, host.pad1_6btn}, six);
    endtask

    // Entered at the falling edge of the first busy cycle; leaves one cycle after done.
    task automatic checkScan(input string tag);
        logic [11:0] e1;
        logic [11:0] e2;
        logic [1:0]  es;
        e1 = expectWord(pad_type[0], pad_btn[0]);
        e2 = expectWord(pad_type[1], pad_btn[1]);
        es = {pad_type[1] == PAD_6BTN, pad_type[0] == PAD_6BTN};
        for (int i = 0; i < SCAN_LEN; i++) begin
            int   p;
            logic [3:0] want;
            p    = i / (2 * SETTLE);
            want = {1'b1, 1'b0, (p % 2) == 0, ((i / SETTLE) % 2) == 1};
            checkOutput($sformatf("%s lines c%0d", tag, i),
                        {host.busy, host.done, joy_mdsel, joy_split}, want);
            @(negedge clk);
        end
        checkOutput({tag, " done lines"}, {host.busy, host.done, joy_mdsel, joy_split}, 4'b0110);
        checkOutput({tag, " joystick1"}, host.joystick1, e1);
        checkOutput({tag, " joystick2"}, host.joystick2, e2);
        checkOutput({tag, " 6btn"}, {host.pad2_6btn, host.pad1_6btn}, es);
        @(negedge clk);
        checkOutput({tag, " after done"}, {host.busy, host.done}, 2'b00);
        checkOutput({tag, " hold"}, {host.joystick2, host.joystick1}, {e2, e1});
    endtask

    // Counts cycles from the done cycle to the next busy cycle.
    task automatic waitLaunch(input string tag);
        int n;
        int done_seen;
        n         = 1;
        done_seen = 0;
        while (!host.busy && n < MIN_GAP + SCAN_LEN) begin
            @(negedge clk);
            n++;
            if (host.done) done_seen++;
        end
        checkOutput({tag, " launch distance"}, n, MIN_GAP + 1);
        checkOutput({tag, " gap done pulses"}, done_seen, 0);
    endtask

    task automatic checkQuiet(input string tag, input int cycles);
        int active;
        active = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (host.busy || host.done) active++;
        end
        checkOutput({tag, " quiet"}, active, 0);
    endtask

    initial begin
        host.start  = 1'b0;
        reset       = 1'b1;
        pad_type[0] = PAD_3BTN;
        pad_type[1] = PAD_3BTN;
        pad_btn[0]  = 12'h000;
        pad_btn[1]  = 12'h000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkIdle("reset", 12'h000, 12'h000, 2'b00);

        repeat (8) @(posedge clk);
        applyStimulus(PAD_6BTN, 12'h8C0, PAD_3BTN, 12'h001);
        checkScan("six3");
        checkQuiet("six3", MIN_GAP + 4);

        applyStimulus(PAD_SMS, 12'h010, PAD_6BTN, randBtn());
        checkScan("sms");
        checkQuiet("sms", MIN_GAP + 4);

        for (int k = 0; k < 6; k++) begin
            setPadsRandom();
            applyStimulus(pad_type[0], pad_btn[0], pad_type[1], pad_btn[1]);
            checkScan($sformatf("rand%0d", k));
            checkQuiet($sformatf("rand%0d", k), MIN_GAP + 4);
        end

        setPadsRandom();
        @(posedge clk);
        #1 host.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkScan($sformatf("held%0d", k));
            setPadsRandom();
            waitLaunch($sformatf("held%0d", k));
        end
        host.start = 1'b0;
        checkScan("held3");
        checkQuiet("held end", SCAN_LEN + 2 * MIN_GAP);

        setPadsRandom();
        applyStimulus(pad_type[0], pad_btn[0], pad_type[1], pad_btn[1]);
        fork
            checkScan("pend0");
            begin
                repeat (9) @(posedge clk);
                #1 host.start = 1'b1;
                @(posedge clk);
                #1 host.start = 1'b0;
                repeat (19) @(posedge clk);
                #1 host.start = 1'b1;
                @(posedge clk);
                #1 host.start = 1'b0;
            end
        join
        setPadsRandom();
        waitLaunch("pend");
        checkScan("pend1");
        checkQuiet("pend single", SCAN_LEN + 2 * MIN_GAP);

        setPadsRandom();
        applyStimulus(pad_type[0], pad_btn[0], pad_type[1], pad_btn[1]);
        repeat (29) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkIdle("midreset", 12'h000, 12'h000, 2'b00);
        checkQuiet("midreset", 40);

        setPadsRandom();
        applyStimulus(pad_type[0], pad_btn[0], pad_type[1], pad_btn[1]);
        checkScan("post reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/joy_db9md_scan.md
Name: joy_db9md_scan

Overview:
Single-clock, on-demand scan sequencer for the Megadrive DB9 splitter. It drives the shared split line and the MD select line, and samples both pads through the one 6-bit input bus. It classifies each pad as SMS, MD 3-button or MD 6-button, and publishes atomic 12-bit active-high button words. Scans are requested per frame, typically from vsync, and a minimum inter-scan gap keeps 6-button pads from losing their select count.

Parameters:
SETTLE, 16, clk cycles per port slot (line settle time); sample taken on last cycle of slot; legal ≥2
MIN_GAP, 4096, clk cycles after done before next scan may launch (6-button counter reset window); legal ≥1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  scan request pulse/level, sampled every cycle
joy_in  in  6  active-low pad lines from splitter: [5]C/Start [4]B/A [3]U/Z [2]D/Y [1]L/X [0]R/Mode
joy_mdsel  out  1  MD select line to both pads
joy_split  out  1  splitter port select: 0=port1, 1=port2
busy  out  1  scan in progress
done  out  1  one-cycle pulse, joystick outputs updated this cycle
joystick1  out  12  port1 active-high: [11]Z [10]Y [9]X [8]Mode [7]Start [6]A [5]C [4]B [3]U [2]D [1]L [0]R
joystick2  out  12  port2, same format
pad1_6btn  out  1  port1 identified as 6-button in last completed scan
pad2_6btn  out  1  port2 identified as 6-button in last completed scan

Behaviour:
- Reset: joy_mdsel=1, joy_split=0, busy=0, done=0, joystick1/2=0, pad*_6btn=0, pending=0, gap counter expired. Reset mid-scan aborts immediately; shadow data is discarded.
- FSM: IDLE, GAP, SCAN.
  - IDLE + (start|pending) -> SCAN.
  - SCAN end -> GAP with gap counter=MIN_GAP.
  - GAP counts down; at 0 -> IDLE.
- Request: start=1 in any state other than a launching IDLE sets pending. Launch clears pending. Multiple requests collapse to one.
- Launch: request seen in IDLE at cycle t -> busy=1 and phase 0 slot 0 driven from t+1.
- SCAN: 8 phases p=0..7, each 2 slots (split=0 then split=1), each slot SETTLE cycles. Total scan = 16*SETTLE cycles.
  - joy_mdsel = 1 for even p, 0 for odd p.
  - joy_split changes only at slot boundaries.
  - Last SCAN cycle is t+16*SETTLE.
- Capture per port, raw = joy_in sampled on the last cycle of that port's slot:
  - p0: shadow[5:0] = ~raw[5:0].
  - p1: if raw[1:0]==00 (MD pad), shadow[7:6] = ~raw[5:4] and md=1. Else shadow[7:6]=00 and md=0 (SMS: B/C bits are buttons 1/2).
  - p3: six = md & (raw[3:0]==0000).
  - p4: if six, shadow[11:8] = ~raw[3:0]. Else shadow[11:8]=0000.
  - p2, p5, p6, p7: select toggles only, no capture.
- Completion at cycle t+16*SETTLE+1:
  - joystick1/2 and pad*_6btn load from shadow in the same cycle, atomically.
  - done=1 for that single cycle; busy=0; joy_mdsel=1; joy_split=0.
  - Outputs hold until the next done or reset.
- Idle/GAP line state: joy_mdsel=1, joy_split=0.
- Next launch: no earlier than done cycle + MIN_GAP + 1.
- start asserted on the done cycle sets pending.
- Counter widths: sized for SETTLE and MIN_GAP; no wrap inside a scan.

Test Plan:
- SETTLE=4, MIN_GAP=32; reset; start pulse at cycle 10 -> busy 11..74, done at cycle 75 only. joy_mdsel toggles every 8 cycles starting 1; joy_split toggles every 4 cycles starting 0.
- Port1 modelled as 6-button pad with A+Start+Z pressed, port2 as 3-button with Right pressed. After done: joystick1=0x8C0, pad1_6btn=1; joystick2=0x001, pad2_6btn=0.
- Port1 modelled as SMS pad (raw[1:0]=11 at sel=0) with button 1 pressed (raw[4]=0). After done: joystick1=0x010, bits[11:6]=0.
- start held high continuously -> scans launch exactly every 64+32+1 cycles. One done per scan; no launch during GAP.
- start pulses at cycles 20 and 40 during a scan -> exactly one further scan, launching when GAP expires.
- reset asserted at mid-scan cycle 40 -> next cycle: busy=0, joy_mdsel=1, joy_split=0, joystick outputs 0, no done. Fresh start produces a normal full scan.
